// File: rtl/lattice_pkg.sv
// Shared definitions for the lattice evaluation blocks: mode encoding and
// fixed-point helper functions.
package lattice_pkg;

  localparam logic MODE_EUROPEAN = 1'b0;
  localparam logic MODE_AMERICAN = 1'b1;

  // Fixed-point representation of 1.0 with f fractional bits.
  function automatic logic [63:0] fx_one(input int f);
    return 64'(1) << f;
  endfunction

  // Largest unsigned value representable in w bits (w capped at 64).
  function automatic logic [63:0] sat_max(input int w);
    if (w >= 64) return '1;
    return (64'(1) << w) - 64'(1);
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational unsigned W x W fixed-point multiply: the product is shifted
// right by F (truncating) and clamped to all-ones when it does not fit W bits.
module fx_mul_sat
  import lattice_pkg::*;
#(
  parameter int W = 32,
  parameter int F = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [2*W-1:0] prod;

  // Any bit of the shifted product above W means the value overflows.
  function automatic logic [W-1:0] sat_shift(input logic [2*W-1:0] full);
    logic [2*W-1:0] shifted;
    shifted = full >> F;
    if (|shifted[2*W-1:W]) return MAX;
    return shifted[W-1:0];
  endfunction

  // Full-precision product, then scale back to F fractional bits.
  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p    = sat_shift(prod);
  end

endmodule

// File: rtl/eval_node_pipe.sv
// Three-stage lattice node evaluator: hold = p_up*v_up + p_down*v_down,
// compared against the exercise value under an American/European mode.
// The whole pipeline stalls together when the output is not taken, and a
// saturating counter tallies delivered early-exercise results.
module eval_node_pipe
  import lattice_pkg::*;
#(
  parameter int W       = 32,
  parameter int F       = 24,
  parameter int TAG_W   = 16,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [W-1:0]       p_up,
  input  logic [W-1:0]       p_down,
  input  logic [W-1:0]       v_up,
  input  logic [W-1:0]       v_down,
  input  logic [W-1:0]       v_ex,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       result,
  output logic               exercise,
  output logic [TAG_W-1:0]   tag_out,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] ex_count
);

  localparam logic [W-1:0]       MAX     = W'(sat_max(W));
  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(sat_max(COUNT_W));

  // Two-operand add with clamp to all-ones on carry out.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? MAX : s[W-1:0];
  endfunction

  // Counter increment that sticks at its maximum.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + COUNT_W'(1);
  endfunction

  logic               adv;
  logic               vld_p0, vld_p1, vld_p2;
  logic               mode_p0, mode_p1;
  logic [TAG_W-1:0]   tag_p0, tag_p1;
  logic [W-1:0]       mul_up, mul_dn;
  logic [W-1:0]       mul_up_p0, mul_dn_p0, vex_p0;
  logic [W-1:0]       hold_p1, vex_p1;
  logic               ex_sel;

  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  fx_mul_sat #(.W(W), .F(F)) u_mul_up (
    .a (p_up),
    .b (v_up),
    .p (mul_up)
  );

  fx_mul_sat #(.W(W), .F(F)) u_mul_dn (
    .a (p_down),
    .b (v_down),
    .p (mul_dn)
  );

  // Valid bits advance together only when the output slot is free or taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p0: register both saturated products with exercise value, mode, tag.
  always_ff @(posedge clk) begin
    if (adv) begin
      mul_up_p0 <= mul_up;
      mul_dn_p0 <= mul_dn;
      vex_p0    <= v_ex;
      mode_p0   <= mode;
      tag_p0    <= tag_in;
    end
  end

  // Stage p1: saturating sum forms the hold value; side data follows it.
  always_ff @(posedge clk) begin
    if (adv) begin
      hold_p1 <= sat_add(mul_up_p0, mul_dn_p0);
      vex_p1  <= vex_p0;
      mode_p1 <= mode_p0;
      tag_p1  <= tag_p0;
    end
  end

  // Exercise only when allowed and strictly better; ties keep the hold value.
  assign ex_sel = (mode_p1 == MODE_AMERICAN) && (vex_p1 > hold_p1);

  // Stage p2: selected node value, decision flag and tag drive the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      exercise <= 1'b0;
      tag_out  <= '0;
    end else if (adv) begin
      result   <= ex_sel ? vex_p1 : hold_p1;
      exercise <= ex_sel;
      tag_out  <= tag_p1;
    end
  end

  // Count exercised results as they are handed off; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ex_count <= '0;
    end else if (vld_p2 && out_ready && exercise) begin
      ex_count <= sat_inc(ex_count);
    end
  end

endmodule
